pc_source_reg: RTL and testbench
================================

Name: pc_source_reg

Overview:
- Parametrised successor to the combinational PC-source multiplexer.
- Selects the next-PC value from NUM_SRC flattened source buses and holds it in the architectural PC register.
- Supports unconditional and branch-conditional writes, exception capture into EPC, alignment checking, and a one-cycle update strobe for the control unit's multicycle FSM.
- Sits between the ALU/ALUOut/shift/exception-vector paths and the instruction-memory address mux.

Parameters:
- WIDTH, 32, data width of every source, PC and EPC.
- NUM_SRC, 6, number of next-PC sources; must be ≥2.
- SEL_W, $clog2(NUM_SRC), select width; derived, never overridden.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- ALIGN_CHECK, 1, 1 = reject next-PC values with bits [1:0] ≠ 0; 0 = no check.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- src_bus, input, NUM_SRC*WIDTH, flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel, input, SEL_W, source select.
- pc_write, input, 1, unconditional PC write.
- pc_write_cond, input, 1, conditional PC write (branch).
- cond_true, input, 1, branch condition from the ALU/compare path.
- exc_take, input, 1, exception entry; capture EPC this cycle.
- err_clr, input, 1, clear align_err.
- next_pc, output, WIDTH, combinational selected source.
- pc, output, WIDTH, registered PC.
- epc, output, WIDTH, registered exception PC.
- pc_updated, output, 1, one-cycle pulse after the PC changed.
- align_err, output, 1, sticky misalignment flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_VEC, epc = 0, pc_updated = 0, align_err = 0.
  - Asserting reset mid-cycle overrides any pending write immediately.
  - Deassertion takes effect on the next rising edge.
- Select:
  - next_pc = source[sel] when sel < NUM_SRC.
  - Any sel ≥ NUM_SRC yields source[NUM_SRC-1].
  - Purely combinational, zero latency.
- Write enable: we = pc_write | (pc_write_cond & cond_true).
  - pc_write_cond with cond_true=0 does not write.
- Misalignment: mis = ALIGN_CHECK & we & (next_pc[1:0] ≠ 2'b00).
- Per rising edge, in priority order:
  1. If mis:
     - pc holds its value.
     - epc <= pc (current value).
     - align_err <= 1.
     - pc_updated <= 0.
     - exc_take in the same cycle is absorbed; epc is still written once with the current pc.
  2. Else if we:
     - pc <= next_pc.
     - pc_updated <= 1, even when next_pc equals the old pc.
     - If exc_take is also high, epc <= old pc in the same edge (vector load and EPC save are one step).
  3. Else:
     - pc holds; pc_updated <= 0.
     - If exc_take, epc <= pc.
- pc_updated:
  - High for exactly the cycle after a successful write.
  - Back-to-back writes keep it high continuously.
- align_err:
  - Set by mis; cleared by err_clr on the next edge.
  - If mis and err_clr occur in the same cycle, set wins.
  - Cleared only by err_clr or reset.
- epc:
  - Changes only on exc_take or mis; otherwise holds.
- Latency:
  - next_pc to pc: 1 clock.
  - Write to pc_updated: 1 clock, aligned with the new pc.
- All registers sit in a single always block sensitive to posedge clk / negedge reset; no latches.
- next_pc is never registered.

Test Plan:
- Reset and sources:
  - Stimulus: hold reset=0 for 2 cycles with pc_write=1, then release; sources k = 32'h100+4k.
  - Required: pc = 0 during reset; one edge after release with sel=3, pc = 32'h10C and pc_updated = 1 on that cycle only.
- Select sweep:
  - Stimulus: sel = 0..7 (NUM_SRC=6), pc_write=1 each cycle.
  - Required: pc sequence 100, 104, 108, 10C, 110, 114, 114, 114; pc_updated stays high throughout.
- Conditional write:
  - Stimulus: pc = 32'h40, pc_write_cond=1, cond_true=0, then cond_true=1 with source = 32'h80.
  - Required: pc stays 32'h40 with pc_updated = 0, then pc = 32'h80 with a one-cycle pulse.
- Exception entry:
  - Stimulus: pc = 32'h200, exc_take=1, pc_write=1, sel selects vector 32'hFC.
  - Required: epc = 32'h200 and pc = 32'hFC after the same edge; epc unchanged over the following 5 idle cycles.
- Misalignment:
  - Stimulus: pc = 32'h300, pc_write=1 with next_pc = 32'h302.
  - Required: pc stays 32'h300, epc = 32'h300, align_err = 1, pc_updated = 0.
  - Then err_clr=1 together with a fresh misaligned write: align_err stays 1.
  - Then err_clr alone: align_err = 0.
  - Repeat with ALIGN_CHECK=0: pc = 32'h302.
- Async reset mid-operation:
  - Stimulus: drop reset between clock edges while pc = 32'h500 and align_err = 1.
  - Required: pc = RESET_VEC, epc = 0, align_err = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_source_reg.sv
// Next-PC source selection and architectural PC/EPC register with branch-conditional
// writes, alignment checking, sticky misalignment flag and a one-cycle update strobe.
module pc_source_reg #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_SRC     = 6,
    localparam int              SEL_W       = $clog2(NUM_SRC),
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter bit               ALIGN_CHECK = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     cond_true,
    input  logic                     exc_take,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         next_pc,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         epc,
    output logic                     pc_updated,
    output logic                     align_err
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_pc_updated;
    logic             r_align_err;

    logic [WIDTH-1:0] w_next_pc;
    logic             w_we;
    logic             w_mis;

    // Out-of-range selects fall through to the last source.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_pc unassigned (no latch).
        w_next_pc = src_bus[(NUM_SRC-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            if (int'(sel) == k) begin
                w_next_pc = src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_we  = pc_write | (pc_write_cond & cond_true);
    assign w_mis = ALIGN_CHECK && w_we && (w_next_pc[1:0] != 2'b00);

    // A misaligned write becomes an exception: PC holds, EPC saves it, flag sets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VEC;
            r_epc        <= '0;
            r_pc_updated <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge r_pc.
            r_pc_updated <= 1'b0;
            if (w_mis) begin
                r_epc       <= r_pc;
                r_align_err <= 1'b1;
            end else begin
                if (err_clr) begin
                    r_align_err <= 1'b0;
                end
                if (w_we) begin
                    r_pc         <= w_next_pc;
                    r_pc_updated <= 1'b1;
                end
                if (exc_take) begin
                    r_epc <= r_pc;
                end
            end
        end
    end

    assign next_pc    = w_next_pc;
    assign pc         = r_pc;
    assign epc        = r_epc;
    assign pc_updated = r_pc_updated;
    assign align_err  = r_align_err;

endmodule

// File: tb/tb_pc_source_reg.sv
// Scoreboard bench for pc_source_reg: two instances (alignment check on/off) share
// stimulus; a reference model pushes expectations, a monitor pops and compares.
module tb_pc_source_reg;

    localparam int NSRC = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        upd;
        logic        err;
    } st_t;

    typedef struct packed {
        logic [31:0] npc;
        st_t         a;
        st_t         b;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       src [NSRC];
    logic [NSRC*32-1:0] src_bus;
    logic [2:0]        sel;
    logic              pc_write, pc_write_cond, cond_true, exc_take, err_clr;

    logic [31:0] npc_a, pc_a, epc_a, npc_b, pc_b, epc_b;
    logic        upd_a, err_a, upd_b, err_b;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    st_t  m_a, m_b;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NSRC; k++) src_bus[k*32 +: 32] = src[k];
    end

    pc_source_reg #(.WIDTH(32), .NUM_SRC(NSRC), .RESET_VEC(32'h0), .ALIGN_CHECK(1'b1)) dut_a (
        .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
        .exc_take(exc_take), .err_clr(err_clr),
        .next_pc(npc_a), .pc(pc_a), .epc(epc_a), .pc_updated(upd_a), .align_err(err_a));

    pc_source_reg #(.WIDTH(32), .NUM_SRC(NSRC), .RESET_VEC(32'h0), .ALIGN_CHECK(1'b0)) dut_b (
        .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
        .exc_take(exc_take), .err_clr(err_clr),
        .next_pc(npc_b), .pc(pc_b), .epc(epc_b), .pc_updated(upd_b), .align_err(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One architectural step: misaligned write traps, else write and/or EPC save.
    function automatic st_t model(st_t s, bit align_on, logic [31:0] npc, bit we, bit exc, bit clr);
        st_t n = s;
        n.upd = 1'b0;
        if (align_on && we && (npc % 4 != 0)) begin
            n.epc = s.pc;
            n.err = 1'b1;
        end else begin
            if (clr) n.err = 1'b0;
            if (we) begin
                n.pc  = npc;
                n.upd = 1'b1;
            end
            if (exc) n.epc = s.pc;
        end
        return n;
    endfunction

    task automatic cycle();
        int          idx = (int'(sel) >= NSRC) ? NSRC - 1 : int'(sel);
        logic [31:0] npc = src[idx];
        bit          we  = pc_write || (pc_write_cond && cond_true);
        m_a = model(m_a, 1'b1, npc, we, exc_take, err_clr);
        m_b = model(m_b, 1'b0, npc, we, exc_take, err_clr);
        q.push_back('{npc, m_a, m_b});
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; cond_true = 0; exc_take = 0; err_clr = 0;
    endtask

    task automatic write_src(input int k, input logic [31:0] v);
        src[k] = v;
        sel = 3'(k);
        pc_write = 1'b1;
        cycle();
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("next_pc_a", npc_a, e.npc);
                check("next_pc_b", npc_b, e.npc);
                check("pc_a", pc_a, e.a.pc);
                check("epc_a", epc_a, e.a.epc);
                check("upd_a", 32'(upd_a), 32'(e.a.upd));
                check("err_a", 32'(err_a), 32'(e.a.err));
                check("pc_b", pc_b, e.b.pc);
                check("epc_b", epc_b, e.b.epc);
                check("upd_b", 32'(upd_b), 32'(e.b.upd));
                check("err_b", 32'(err_b), 32'(e.b.err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        reset = 1'b0;
        for (int k = 0; k < NSRC; k++) src[k] = 32'h100 + 32'(4 * k);
        idle();
        sel = 3'd3;
        pc_write = 1'b1;
        m_a = '0;
        m_b = '0;
        repeat (2) @(posedge clk);
        #3;
        check("pc_in_reset_a", pc_a, 32'h0);
        check("upd_in_reset_a", 32'(upd_a), 32'h0);
        reset = 1'b1;
        cycle();                       // pc = 10C, pulse
        idle();
        cycle();                       // pulse drops

        // Select sweep including out-of-range selects
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            pc_write = 1'b1;
            cycle();
        end
        idle();

        // Conditional write
        write_src(0, 32'h40);
        src[1] = 32'h80;
        sel = 3'd1;
        pc_write_cond = 1'b1;
        cond_true = 1'b0;
        cycle();
        cond_true = 1'b1;
        cycle();
        idle();
        cycle();

        // Exception entry with vector load, then EPC must hold
        write_src(2, 32'h200);
        src[5] = 32'hFC;
        sel = 3'd5;
        pc_write = 1'b1;
        exc_take = 1'b1;
        cycle();
        idle();
        repeat (5) cycle();

        // Misalignment trap, set-beats-clear, then clear
        write_src(0, 32'h300);
        src[1] = 32'h302;
        sel = 3'd1;
        pc_write = 1'b1;
        cycle();
        err_clr = 1'b1;
        src[2] = 32'h305;
        sel = 3'd2;
        cycle();
        idle();
        err_clr = 1'b1;
        cycle();
        idle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom;
                if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
                src[$urandom_range(0, NSRC - 1)] = r;
            end
            sel           = 3'($urandom_range(0, 7));
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            cond_true     = ($urandom_range(0, 1) == 0);
            exc_take      = ($urandom_range(0, 7) == 0);
            err_clr       = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle();

        // Asynchronous reset between edges while pc = 500 and align_err = 1
        write_src(0, 32'h500);
        src[1] = 32'h501;
        sel = 3'd1;
        pc_write = 1'b1;
        cycle();
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("async_pc_a", pc_a, 32'h0);
        check("async_epc_a", epc_a, 32'h0);
        check("async_err_a", 32'(err_a), 32'h0);
        check("async_pc_b", pc_b, 32'h0);
        check("async_epc_b", epc_b, 32'h0);
        m_a = '0;
        m_b = '0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        write_src(4, 32'h710);
        cycle();

        repeat (2) @(posedge clk);
        #2;
        check("queue_drain", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
